// File: rtl/pam4_channel_pkg.sv
// pam4_channel_pkg: shared definitions for the PAM4 burst-error channel.
//   - gray_to_level / level_to_gray : gray symbol <-> PAM4 level mapping
//                                     (00->0, 01->1, 11->2, 10->3)
//   - thr_fire                      : threshold rule, fires iff {0,rand} < thr
//   - LFSR_TAPS                     : Galois taps for x^32+x^22+x^2+x+1
//   - THR_W                         : width of probability thresholds (0..65536)
//   - ch_state_t                    : Gilbert-Elliott state encoding
package pam4_channel_pkg;

   localparam int unsigned THR_W     = 17;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic {
      ST_GOOD = 1'b0,
      ST_BAD  = 1'b1
   } ch_state_t;

   function automatic logic [1:0] gray_to_level(input logic [1:0] g);
      logic [1:0] lvl;
      case (g)
         2'b00:   lvl = 2'd0;
         2'b01:   lvl = 2'd1;
         2'b11:   lvl = 2'd2;
         default: lvl = 2'd3;
      endcase
      return lvl;
   endfunction

   function automatic logic [1:0] level_to_gray(input logic [1:0] lvl);
      return lvl ^ {1'b0, lvl[1]};
   endfunction

   // Threshold of 0 never fires, 65536 always fires.
   function automatic logic thr_fire(input logic [15:0] rnd,
                                     input logic [THR_W-1:0] thr);
      return ({1'b0, rnd} < thr);
   endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// lfsr32_galois: 32-bit right-shifting Galois LFSR (taps LFSR_TAPS).
// Shared with PRBS generator/checker blocks.
// Ports:
//   clk   - clock
//   rstn  - synchronous active-low reset, loads seed (0 replaced by 1)
//   step  - advance by one position this cycle
//   seed  - reset value
//   value - current LFSR contents
module lfsr32_galois
   import pam4_channel_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] value
);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         // An all-zero state would lock the register forever.
         value <= (seed == 32'd0) ? 32'd1 : seed;
      end else if (step) begin
         value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'd0);
      end
   end

endmodule

// File: rtl/pam4_burst_channel.sv
// pam4_burst_channel: bursty adjacent-level error channel for gray PAM4
// symbols, sitting between the symbol encoder and decoder.
// A Gilbert-Elliott GOOD/BAD FSM, driven by an internal LFSR, selects the
// per-symbol error probability; errors move the symbol one PAM4 level,
// which is a single-bit flip in gray coding.
//
// Interface: valid-only streaming, no backpressure. A symbol is accepted
// on every clock where valid_in=1; it appears on sym_out exactly one cycle
// later with valid_out=1. With valid_in=0 nothing advances and sym_out
// holds its previous value.
//
// Ports:
//   clk, rstn   - clock, synchronous active-low reset
//   en          - 1: inject errors, 0: transparent (LFSR still advances)
//   sym_in      - gray symbol from the encoder, qualified by valid_in
//   sym_out     - registered, possibly corrupted symbol, qualified by valid_out
//   err_flag    - sym_out differs from the input symbol
//   state_bad   - FSM state (1 = BAD)
//   err_count   - injected error count; only built when
//                 PAM4_CHANNEL_ERR_COUNT_EN is defined, otherwise 0
module pam4_burst_channel
   import pam4_channel_pkg::*;
#(
   parameter logic [31:0]      SEED       = 32'h1,
   parameter logic [THR_W-1:0] P_G2B      = 17'd0,
   parameter logic [THR_W-1:0] P_B2G      = 17'd65536,
   parameter logic [THR_W-1:0] P_ERR_GOOD = 17'd0,
   parameter logic [THR_W-1:0] P_ERR_BAD  = 17'd0
)
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic [1:0]  sym_in,
   input  logic        valid_in,
   output logic [1:0]  sym_out,
   output logic        valid_out,
   output logic        err_flag,
   output logic        state_bad,
   output logic [31:0] err_count
);

   logic [31:0]      lfsr_val;
   logic [15:0]      err_rand;
   logic [15:0]      trans_rand;
   logic             dir;
   ch_state_t        state_q;
   ch_state_t        state_d;
   logic [THR_W-1:0] err_thr;
   logic [THR_W-1:0] trans_thr;
   logic             err_fire;
   logic [1:0]       lvl_in;
   logic [1:0]       lvl_new;
   logic [1:0]       sym_new;

   // The LFSR steps once per accepted symbol, independent of en, so the
   // random stream stays aligned with the symbol stream.
   lfsr32_galois u_lfsr (
      .clk   (clk),
      .rstn  (rstn),
      .step  (valid_in),
      .seed  (SEED),
      .value (lfsr_val)
   );

   // All fields come from the pre-step LFSR value.
   assign err_rand   = lfsr_val[15:0];
   assign trans_rand = lfsr_val[31:16];
   assign dir        = lfsr_val[0] ^ lfsr_val[31];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_GOOD;
      end else begin
         state_q <= state_d;
      end
   end

   // Error decision uses the current state; the transition takes effect
   // for the next accepted symbol.
   always_comb begin
      state_d   = state_q;
      err_thr   = P_ERR_GOOD;
      trans_thr = P_G2B;
      if (state_q == ST_BAD) begin
         err_thr   = P_ERR_BAD;
         trans_thr = P_B2G;
      end
      err_fire = valid_in && en && thr_fire(err_rand, err_thr);
      if (valid_in && en && thr_fire(trans_rand, trans_thr)) begin
         state_d = (state_q == ST_GOOD) ? ST_BAD : ST_GOOD;
      end
   end

   // Adjacent-level move: edge levels can only move inward.
   always_comb begin
      lvl_in = gray_to_level(sym_in);
      case (lvl_in)
         2'd0:    lvl_new = 2'd1;
         2'd3:    lvl_new = 2'd2;
         default: lvl_new = dir ? (lvl_in + 2'd1) : (lvl_in - 2'd1);
      endcase
      sym_new = err_fire ? level_to_gray(lvl_new) : sym_in;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sym_out   <= 2'b00;
         valid_out <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         valid_out <= valid_in;
         err_flag  <= err_fire;
         if (valid_in) begin
            sym_out <= sym_new;
         end
      end
   end

   assign state_bad = (state_q == ST_BAD);

`ifdef PAM4_CHANNEL_ERR_COUNT_EN
   logic [31:0] err_cnt_q;

   // Counts alongside err_flag so err_count and err_flag update together.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_cnt_q <= 32'd0;
      end else if (err_fire && (err_cnt_q != 32'hFFFF_FFFF)) begin
         err_cnt_q <= err_cnt_q + 32'd1;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 32'd0;
`endif

endmodule

// File: tb/tb_pam4_burst_channel.sv
// tb_pam4_burst_channel: two channel instances with different thresholds
// share one stimulus stream. A reference model predicts each output;
// predictions are queued when stimulus is driven and compared when the
// DUT presents valid_out.
//   dut0: SEED=32'h1234_5678, moderate GOOD/BAD probabilities
//   dut1: SEED=0 (behaves as 1), always GOOD->BAD, never BAD->GOOD,
//         errors only (and always) in BAD
module tb_pam4_burst_channel;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic [1:0]  sym_in;
   logic        valid_in;

   logic [1:0]  so0, so1;
   logic        vo0, vo1, ef0, ef1, sb0, sb1;
   logic [31:0] ec0, ec1;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   pam4_burst_channel #(
      .SEED(32'h1234_5678), .P_G2B(17'd8192), .P_B2G(17'd16384),
      .P_ERR_GOOD(17'd4096), .P_ERR_BAD(17'd40000)
   ) dut0 (
      .clk(clk), .rstn(rstn), .en(en), .sym_in(sym_in), .valid_in(valid_in),
      .sym_out(so0), .valid_out(vo0), .err_flag(ef0), .state_bad(sb0),
      .err_count(ec0)
   );

   pam4_burst_channel #(
      .SEED(32'h0), .P_G2B(17'd65536), .P_B2G(17'd0),
      .P_ERR_GOOD(17'd0), .P_ERR_BAD(17'd65536)
   ) dut1 (
      .clk(clk), .rstn(rstn), .en(en), .sym_in(sym_in), .valid_in(valid_in),
      .sym_out(so1), .valid_out(vo1), .err_flag(ef1), .state_bad(sb1),
      .err_count(ec1)
   );

   // ---------------- reference model ----------------
   logic [31:0] seed_eff [2] = '{32'h1234_5678, 32'h1};
   int          p_g2b    [2] = '{8192, 65536};
   int          p_b2g    [2] = '{16384, 0};
   int          p_err_g  [2] = '{4096, 0};
   int          p_err_b  [2] = '{40000, 65536};

   logic [31:0] m_lfsr   [2];
   logic        m_state  [2];
   logic [31:0] m_cnt    [2];
   logic [1:0]  hold_sym [2];

   // Scoreboard: {dut1 {err,sym}, dut0 {err,sym}} per accepted symbol.
   logic [5:0]  exp_q[$];
   logic        exp_v;
   logic        started;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] r);
      if (r[0]) return (r >> 1) ^ 32'h8020_0003;
      return r >> 1;
   endfunction

   function automatic int level_of(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gray_of(input int lvl);
      case (lvl)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [31:0] exp_cnt(input int k);
`ifdef PAM4_CHANNEL_ERR_COUNT_EN
      return m_cnt[k];
`else
      return 32'd0 & m_cnt[k];
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lfsr[k]   = seed_eff[k];
         m_state[k]  = 1'b0;
         m_cnt[k]    = 32'd0;
         hold_sym[k] = 2'b00;
      end
      exp_q.delete();
      exp_v = 1'b0;
   endtask

   // Returns {err, sym} for one accepted symbol on instance k.
   task automatic model_step(input int k, input logic e, input logic [1:0] s,
                             output logic [2:0] res);
      logic [31:0] r;
      int          lvl, thr;
      r         = m_lfsr[k];
      m_lfsr[k] = lfsr_next(r);
      res       = {1'b0, s};
      if (e) begin
         thr = m_state[k] ? p_err_b[k] : p_err_g[k];
         if (int'(r[15:0]) < thr) begin
            lvl = level_of(s);
            if (lvl == 0)      lvl = 1;
            else if (lvl == 3) lvl = 2;
            else if (r[0] ^ r[31]) lvl = lvl + 1;
            else               lvl = lvl - 1;
            res = {1'b1, gray_of(lvl)};
            m_cnt[k] = m_cnt[k] + 32'd1;
         end
         thr = m_state[k] ? p_b2g[k] : p_g2b[k];
         if (int'(r[31:16]) < thr) m_state[k] = ~m_state[k];
      end
   endtask

   // ---------------- driver + monitor ----------------
   // Each call: check what the previous edge produced, then drive the
   // next inputs and advance the model.
   task automatic cycle(input logic r_v, input logic e_v, input logic v_v,
                        input logic [1:0] s_v);
      logic [5:0] e;
      logic [2:0] r0, r1;
      @(negedge clk);
      if (started) begin
         check("valid_out0", 32'(vo0), 32'(exp_v));
         check("valid_out1", 32'(vo1), 32'(exp_v));
         if (exp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sym_out0", 32'(so0), 32'(e[1:0]));
            check("err_flag0", 32'(ef0), 32'(e[2]));
            check("sym_out1", 32'(so1), 32'(e[4:3]));
            check("err_flag1", 32'(ef1), 32'(e[5]));
         end else begin
            check("hold_sym0", 32'(so0), 32'(hold_sym[0]));
            check("hold_sym1", 32'(so1), 32'(hold_sym[1]));
            check("idle_err0", 32'(ef0), 32'd0);
            check("idle_err1", 32'(ef1), 32'd0);
         end
         check("state_bad0", 32'(sb0), 32'(m_state[0]));
         check("state_bad1", 32'(sb1), 32'(m_state[1]));
         check("err_count0", ec0, exp_cnt(0));
         check("err_count1", ec1, exp_cnt(1));
      end
      rstn     = r_v;
      en       = e_v;
      valid_in = v_v;
      sym_in   = s_v;
      if (!r_v) begin
         model_reset();
      end else begin
         exp_v = v_v;
         if (v_v) begin
            model_step(0, e_v, s_v, r0);
            model_step(1, e_v, s_v, r1);
            hold_sym[0] = r0[1:0];
            hold_sym[1] = r1[1:0];
            exp_q.push_back({r1, r0});
         end
      end
      started = 1'b1;
   endtask

   function automatic logic [1:0] gray_seq(input int i);
      return gray_of(i % 4);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rstn     = 1'b0;
      en       = 1'b0;
      valid_in = 1'b0;
      sym_in   = 2'b00;
      started  = 1'b0;
      model_reset();

      cycle(1'b0, 1'b0, 1'b0, 2'b00);
      cycle(1'b0, 1'b0, 1'b0, 2'b00);

      // Random symbols with gaps, channel active.
      for (int i = 0; i < 300; i++)
         cycle(1'b1, 1'b1, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)));

      // Transparent window: 50 valids with en=0, then re-enable.
      for (int i = 0; i < 50; i++)
         cycle(1'b1, 1'b0, 1'b1, gray_seq(i));
      cycle(1'b1, 1'b0, 1'b0, 2'b00);

      // Edge levels only (00 and 10).
      for (int i = 0; i < 200; i++)
         cycle(1'b1, 1'b1, ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);

      // Inner level 01: direction depends on the LFSR.
      for (int i = 0; i < 200; i++)
         cycle(1'b1, 1'b1, 1'b1, 2'b01);

      // Inner level 11.
      for (int i = 0; i < 100; i++)
         cycle(1'b1, 1'b1, ($urandom_range(0, 3) != 0), 2'b11);

      // Reset pulse mid-stream with valid_in=1, then a fresh sequence.
      cycle(1'b0, 1'b1, 1'b1, 2'b01);
      for (int i = 0; i < 400; i++)
         cycle(1'b1, 1'b1, 1'b1, gray_seq(i));

      // Toggle en while streaming; the FSM must keep its state.
      for (int i = 0; i < 200; i++)
         cycle(1'b1, ($urandom_range(0, 1) != 0), ($urandom_range(0, 9) < 8),
               2'($urandom_range(0, 3)));

      repeat (3) cycle(1'b1, 1'b1, 1'b0, 2'b00);
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pam4_burst_channel.md
Name: pam4_burst_channel

Overview:
- Channel model between the gray PAM4 symbol encoder and the gray symbol decoder.
- Consumes encoded symbols with a valid strobe and returns them after exactly 1 cycle.
- Injects adjacent-level symbol errors, i.e. single-bit errors in gray coding.
- A two-state Gilbert-Elliott FSM (GOOD/BAD) driven by an internal LFSR produces bursty errors, so FEC can be exercised against realistic error statistics.

Parameters:
- SEED, 32'h1, initial LFSR value; a value of 0 is replaced by 32'h1.
- P_G2B, 17'd0, GOOD->BAD transition threshold, range 0..65536.
- P_B2G, 17'd65536, BAD->GOOD transition threshold, range 0..65536.
- P_ERR_GOOD, 17'd0, symbol error threshold while in GOOD.
- P_ERR_BAD, 17'd0, symbol error threshold while in BAD.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, reset, synchronous, active-low.
- en, in, 1, 1 = channel active; 0 = transparent pass-through.
- sym_in, in, 2, gray symbol from the encoder.
- valid_in, in, 1, sym_in qualifier.
- sym_out, out, 2, possibly corrupted gray symbol.
- valid_out, out, 1, sym_out qualifier.
- err_flag, out, 1, high with valid_out when sym_out != the input symbol.
- state_bad, out, 1, current FSM state (1 = BAD).
- err_count, out, 32, total injected errors.

Behaviour:
- Reset is rstn, synchronous, active-low, on clock clk.
- Reset values: sym_out=0, valid_out=0, err_flag=0, state_bad=0 (GOOD), LFSR=SEED (or 1 if SEED is 0), err_count=0.
- Reset mid-stream discards any in-flight symbol.
- Latency: valid_out(t+1)=valid_in(t), and sym_out is registered.
- When valid_in=0: valid_out=0, err_flag=0, sym_out holds its last value, and the LFSR and FSM do not change.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances exactly once per accepted symbol (valid_in=1), regardless of en.
  - Fields taken from the pre-step value r: err_rand=r[15:0], trans_rand=r[31:16], dir=r[0]^r[31].
- Threshold rule: an event fires iff {1'b0, rand} < threshold. A threshold of 0 never fires; 65536 always fires.
- Per accepted symbol with en=1:
  - Error decision uses the current state: threshold P_ERR_GOOD in GOOD, P_ERR_BAD in BAD.
  - On error: convert the symbol to a level (00->0, 01->1, 11->2, 10->3).
    - Level 1 or 2: dir=1 selects level+1, dir=0 selects level-1.
    - Level 0 always becomes 1; level 3 always becomes 2.
    - Convert the new level back to gray and set err_flag=1.
  - State update in the same cycle, taking effect for the next symbol:
    - GOOD->BAD if trans_rand fires against P_G2B.
    - BAD->GOOD if trans_rand fires against P_B2G.
    - Otherwise the state is held.
- en=0 with valid_in=1:
  - sym_out=sym_in, err_flag=0.
  - The FSM holds its state and the LFSR still advances.
- Toggling en does not reset the FSM.

Optional Feature:
- Macro: PAM4_CHANNEL_ERR_COUNT_EN.
- Defined:
  - err_count increments by 1 on every cycle where err_flag is asserted.
  - It saturates at 32'hFFFF_FFFF and clears only on reset.
- Undefined: err_count is tied to 0 and no counter logic is built.
- The port list is the same in both cases.

Decomposition:
- Package pam4_channel_pkg holds:
  - gray-to-level and level-to-gray functions;
  - the LFSR tap constant 32'h8020_0003;
  - threshold width 17 and the GOOD/BAD state encoding.
- Sub-module lfsr32_galois has ports clk, rstn, step, seed, and value[31:0]. It is shared with future PRBS generator/checker blocks.

Test Plan:
- All P_* thresholds at 0, SEED=1, 1000 valid symbols cycling 00,01,11,10 -> sym_out equals sym_in delayed by 1 cycle, err_flag never asserts, state_bad stays 0.
- P_ERR_GOOD=65536 with inputs 00 and 10 -> outputs are always 01 and 11 respectively (edge levels), err_flag=1 on every valid, err_count=number of valids.
- P_ERR_GOOD=65536 with input 01 -> output is always 00 or 11, matching dir from the reference LFSR model; every output differs from the input in exactly 1 bit.
- P_G2B=65536, P_B2G=0, P_ERR_BAD=65536, P_ERR_GOOD=0 -> first symbol passes unchanged, state_bad=1 from the second symbol on, and every later symbol is corrupted.
- en=0 for 50 valids, then en=1, with P_ERR_GOOD=32768 -> no errors during the en=0 window; the LFSR has advanced 50 steps, so the error pattern after enable matches the model offset by 50.
- rstn pulsed low for 1 cycle mid-stream with valid_in=1 -> valid_out=0 on the next cycle, LFSR returns to SEED, err_count=0, and the output sequence restarts identical to the first run.
